mips_muldiv_unit: RTL

MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

---
 rtl/mips_muldiv_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO multiply-divide unit: iterative radix-2 shift-add multiplier and
// restoring divider sharing one accumulator pair, with MTHI/MTLO and pipeline interlock.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             read_hilo,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             is_div_q, is_div_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_signed, op_is_div, op_arith;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_signed = ~op[0];
  assign op_is_div = op[1];
  assign op_arith  = ~op[2];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;

  // Multiply step: conditionally add the multiplicand into the upper half, then
  // shift the whole {acc_hi, acc_lo} pair right by one, carry included.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;

  assign mul_addend = acc_lo_q[0] ? opb_q : '0;
  assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};

  // Divide step: shift the next dividend bit into the partial remainder and
  // keep the difference only when the trial subtraction does not borrow.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH:0]   div_next;
  logic             div_unused;

  assign div_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, opb_q};
  assign div_ok     = ~div_diff[WIDTH+1];
  assign div_next   = div_ok ? div_diff[WIDTH:0] : div_shift;
  assign div_unused = div_next[WIDTH];

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = qsign_q ? -prod : prod;
  assign quot_fix = qsign_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = rsign_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opb_d    = opb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    is_div_d = is_div_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          if (op_arith) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = op_is_div;
            qsign_d  = a_neg ^ b_neg;
            rsign_d  = a_neg;
            div0_d   = op_is_div && (b == '0);
            acc_hi_d = '0;
            if (op_is_div) begin
              opb_d    = b_abs;
              acc_lo_d = a_abs;
            end else begin
              opb_d    = a_abs;
              acc_lo_d = b_abs;
            end
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end

      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_next[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        // A zero divisor leaves |a| in the remainder; re-signing it restores a exactly.
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = div0_q ? '1 : quot_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      is_div_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opb_q    <= opb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      is_div_q <= is_div_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_FIX);
  assign stall = busy & (start | read_hilo) & ~cancel;

endmodule
